multi_alarm_clock_core: RTL and testbench
=========================================

Name: multi_alarm_clock_core

Overview:
Parametrised successor to the single-alarm digital clock core. Keeps a 24 h time-of-day from a prescaled system clock. Holds N_ALARMS independently enabled alarms and runs a ring/snooze/dismiss state machine with an automatic ring timeout. It also produces a 12 h display hour with a PM flag. It sits between the button/state-machine front end and the LED digit converters.

Parameters:
CLK_HZ, 50000000, clk cycles per second (prescaler terminal count + 1); must be ≥ 2.
N_ALARMS, 4, number of alarm slots (1..8).
RING_SECS, 60, seconds the ring stays active before auto-dismiss (1..255).
SNOOZE_MIN, 5, minutes added to the current time on snooze (1..59).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode12  in  1  1 = disp_hour in 12 h form, 0 = 24 h form
time_wr  in  1  one-cycle pulse: load time from wr_hour/wr_min/wr_sec
wr_hour  in  5  hour to load (0..23)
wr_min  in  6  minute to load (0..59)
wr_sec  in  6  second to load (0..59)
alarm_wr  in  1  one-cycle pulse: write alarm slot alarm_idx
alarm_idx  in  3  slot index (values ≥ N_ALARMS are ignored)
alarm_hour  in  5  alarm hour
alarm_min  in  6  alarm minute
alarm_en  in  1  enable bit written with the slot
snooze  in  1  one-cycle pulse (from button_pulse)
dismiss  in  1  one-cycle pulse (from button_pulse)
hour  out  5  current hour, 0..23
min  out  6  current minute, 0..59
sec  out  6  current second, 0..59
disp_hour  out  5  display hour, 24 h or 12 h (1..12)
pm  out  1  hour ≥ 12
sec_tick  out  1  one-cycle pulse per elapsed second
ringing  out  1  high in RING state
snoozing  out  1  high in SNOOZE state
ring_slot  out  3  slot that caused the current/last ring
wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset: time 00:00:00; prescaler 0; all slots 00:00 and disabled; state IDLE; ringing = snoozing = sec_tick = wr_err = 0; ring_slot = 0.
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - sec_tick = 1 in the cycle where the count = CLK_HZ-1; the count then wraps to 0.
- Time advance on each tick:
  - sec increments; 59 wraps to 0 and carries to min.
  - min 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0.
  - Registered outputs update on the edge ending the tick cycle.
- time_wr:
  - If all fields are in range: loads on the next edge and clears the prescaler to 0. It overrides a tick in the same cycle.
  - If any field is out of range: no change, and wr_err pulses on the next edge.
- alarm_wr:
  - Loads hour/min/en into the slot on the next edge.
  - Rejected with wr_err if alarm_idx ≥ N_ALARMS, alarm_hour > 23 or alarm_min > 59.
  - Does not affect the current ring state.
- Match event:
  - Occurs only in a tick cycle where sec = 59.
  - The next time (sec → 0) is compared against every enabled slot's hour:min.
  - If several slots match, the lowest index wins.
  - The ring starts on the same edge at which sec becomes 0, so ringing is visible together with ss = 00.
  - time_wr never triggers a match.
- State machine (IDLE, RING, SNOOZE):
  - IDLE → RING on match: ring_slot = matching slot, ring seconds counter = 0.
  - RING: the counter increments on each sec_tick. Exits in this order of precedence:
    - dismiss → IDLE.
    - snooze → SNOOZE; target = current hour:min + SNOOZE_MIN, with minute/hour carry and wrap at 24 h (23:58 + 5 → 00:03).
    - counter reaches RING_SECS-1 on a tick → IDLE (auto-dismiss).
    - Match events while in RING are ignored.
  - SNOOZE: exits in this order of precedence:
    - dismiss → IDLE.
    - Snooze target hour:min matched at a sec = 59 tick (same rule as a match event) → RING, ring_slot unchanged, counter = 0.
    - A slot match event at the same time → RING with the new slot; the snooze is cancelled.
    - A snooze pulse in SNOOZE is ignored.
  - Simultaneous snooze and dismiss: dismiss wins.
  - Reset in any state → IDLE with all registers at their reset values.
- disp_hour / pm:
  - mode12 = 0: disp_hour = hour.
  - mode12 = 1: hour 0 → 12; 1..12 → unchanged; 13..23 → hour-12.
  - pm = (hour ≥ 12) in both modes. Both outputs are combinational from hour.

Test Plan:
- CLK_HZ=4. Reset, run 4×86400 cycles → 86400 sec_tick pulses; time returns to 00:00:00 exactly once after passing 23:59:59.
- time_wr 23:59:59 and alarm slot 2 = 00:00 enabled; slot 1 = 00:00 disabled → after 4 cycles time = 00:00:00, ringing = 1, ring_slot = 2.
- Ring with RING_SECS=3 and no input → ringing falls on the 3rd subsequent sec_tick; state IDLE.
- Ring at 23:58:00, snooze pulse, SNOOZE_MIN=5 → snoozing = 1; ringing re-asserts when time reaches 00:03:00 with ring_slot unchanged. Then dismiss together with snooze → IDLE.
- Slots 0 and 3 both = 07:30 and enabled → ring_slot = 0. A second match while ringing leaves ring_slot unchanged.
- Rejected writes (time_wr 24:00:00, alarm_wr idx=5 with N_ALARMS=4, alarm_min=60) → wr_err pulse, no state change. mode12 = 1 at hours 0, 12, 13 → disp_hour 12, 12, 1 and pm 0, 1, 1.

Source files
------------

// File: rtl/multi_alarm_clock_core.sv
// Time-of-day clock with N_ALARMS alarm slots and a ring/snooze/dismiss state machine.
// Also drives a 12/24 h display hour and a PM flag for the LED digit converters.
module multi_alarm_clock_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int N_ALARMS   = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode12,
  input  logic       time_wr,
  input  logic [4:0] wr_hour,
  input  logic [5:0] wr_min,
  input  logic [5:0] wr_sec,
  input  logic       alarm_wr,
  input  logic [2:0] alarm_idx,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       sec_tick,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] ring_slot,
  output logic       wr_err
);

  localparam int          PW      = $clog2(CLK_HZ);
  localparam logic [3:0]  N_SLOTS = 4'(N_ALARMS);
  localparam logic [7:0]  RING_LAST = 8'(RING_SECS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    ring_cnt;
  logic [4:0]    snz_hour;
  logic [5:0]    snz_min;

  logic [4:0] al_hour [N_ALARMS];
  logic [5:0] al_min  [N_ALARMS];
  logic       al_en   [N_ALARMS];

  logic       tick, time_ok, time_load, alarm_ok, alarm_load;
  logic [4:0] nxt_hour, tgt_hour;
  logic [5:0] nxt_sec, nxt_min, tgt_min;
  logic [6:0] tgt_sum;
  logic       match_evt, slot_hit, snz_hit, ring_done;
  logic [2:0] hit_idx;
  logic       start_ring, take_slot, enter_snooze;

  assign tick       = (presc == PW'(CLK_HZ - 1));
  assign sec_tick   = tick;
  assign time_ok    = (wr_hour < 5'd24) && (wr_min < 6'd60) && (wr_sec < 6'd60);
  assign time_load  = time_wr && time_ok;
  assign alarm_ok   = ({1'b0, alarm_idx} < N_SLOTS) && (alarm_hour < 5'd24) && (alarm_min < 6'd60);
  assign alarm_load = alarm_wr && alarm_ok;

  // Time one second ahead; also the value compared against the alarm slots.
  always_comb begin
    nxt_sec  = sec + 6'd1;
    nxt_min  = min;
    nxt_hour = hour;
    if (sec == 6'd59) begin
      nxt_sec = 6'd0;
      if (min == 6'd59) begin
        nxt_min  = 6'd0;
        nxt_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else begin
        nxt_min = min + 6'd1;
      end
    end
  end

  // Snooze target: current hour:min + SNOOZE_MIN, wrapping through midnight.
  always_comb begin
    tgt_sum  = {1'b0, min} + 7'(SNOOZE_MIN);
    tgt_min  = tgt_sum[5:0];
    tgt_hour = hour;
    if (tgt_sum >= 7'd60) begin
      tgt_min  = 6'(tgt_sum - 7'd60);
      tgt_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    slot_hit = 1'b0;
    hit_idx  = 3'd0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (al_en[i] && al_hour[i] == nxt_hour && al_min[i] == nxt_min) begin
        slot_hit = 1'b1;
        hit_idx  = 3'(i);
      end
    end
  end

  assign match_evt = tick && !time_load && (sec == 6'd59);
  assign snz_hit   = match_evt && (nxt_hour == snz_hour) && (nxt_min == snz_min);
  assign ring_done = tick && (ring_cnt == RING_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ring   = 1'b0;
    take_slot    = 1'b0;
    enter_snooze = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (match_evt && slot_hit) begin
          state_nxt  = S_RING;
          start_ring = 1'b1;
          take_slot  = 1'b1;
        end
      end
      S_RING: begin
        if (dismiss) begin
          state_nxt = S_IDLE;
        end else if (snooze) begin
          state_nxt    = S_SNOOZE;
          enter_snooze = 1'b1;
        end else if (ring_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_SNOOZE: begin
        if (dismiss) begin
          state_nxt = S_IDLE;
        end else if (snz_hit) begin
          state_nxt  = S_RING;
          start_ring = 1'b1;
        end else if (match_evt && slot_hit) begin
          state_nxt  = S_RING;
          start_ring = 1'b1;
          take_slot  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ringing  = (state == S_RING);
    snoozing = (state == S_SNOOZE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      hour      <= 5'd0;
      min       <= 6'd0;
      sec       <= 6'd0;
      wr_err    <= 1'b0;
      ring_slot <= 3'd0;
      ring_cnt  <= 8'd0;
      snz_hour  <= 5'd0;
      snz_min   <= 6'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge values.
      wr_err <= (time_wr && !time_ok) || (alarm_wr && !alarm_ok);
      if (time_load) begin
        presc <= '0;
        hour  <= wr_hour;
        min   <= wr_min;
        sec   <= wr_sec;
      end else if (tick) begin
        presc <= '0;
        hour  <= nxt_hour;
        min   <= nxt_min;
        sec   <= nxt_sec;
      end else begin
        presc <= presc + PW'(1);
      end
      if (take_slot) ring_slot <= hit_idx;
      if (start_ring)                    ring_cnt <= 8'd0;
      else if (state == S_RING && tick)  ring_cnt <= ring_cnt + 8'd1;
      if (enter_snooze) begin
        snz_hour <= tgt_hour;
        snz_min  <= tgt_min;
      end
    end
  end

  // NOTE: the slot array is small and must read as disabled after reset, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        al_hour[i] <= 5'd0;
        al_min[i]  <= 6'd0;
        al_en[i]   <= 1'b0;
      end
    end else if (alarm_load) begin
      al_hour[alarm_idx] <= alarm_hour;
      al_min[alarm_idx]  <= alarm_min;
      al_en[alarm_idx]   <= alarm_en;
    end
  end

  always_comb begin
    disp_hour = hour;
    if (mode12) begin
      if (hour == 5'd0)      disp_hour = 5'd12;
      else if (hour > 5'd12) disp_hour = hour - 5'd12;
    end
    pm = (hour >= 5'd12);
  end

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Randomized and directed bench for multi_alarm_clock_core against a seconds-of-day reference model.
module tb_multi_alarm_clock_core;

  localparam int CLK_HZ     = 4;
  localparam int N_ALARMS   = 4;
  localparam int RING_SECS  = 3;
  localparam int SNOOZE_MIN = 5;

  logic       clk = 1'b0;
  logic       reset, mode12, time_wr, alarm_wr, alarm_en, snooze, dismiss;
  logic [4:0] wr_hour, alarm_hour;
  logic [5:0] wr_min, wr_sec, alarm_min;
  logic [2:0] alarm_idx;
  logic [4:0] hour, disp_hour;
  logic [5:0] min, sec;
  logic       pm, sec_tick, ringing, snoozing, wr_err;
  logic [2:0] ring_slot;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time as seconds of day, snooze target as minute of day.
  int m_t, m_p, m_st, m_rc, m_slot, m_tgt, m_err;
  int m_sh [N_ALARMS];
  int m_sm [N_ALARMS];
  int m_se [N_ALARMS];

  multi_alarm_clock_core #(
    .CLK_HZ(CLK_HZ), .N_ALARMS(N_ALARMS), .RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .reset(reset), .mode12(mode12),
    .time_wr(time_wr), .wr_hour(wr_hour), .wr_min(wr_min), .wr_sec(wr_sec),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .alarm_en(alarm_en),
    .snooze(snooze), .dismiss(dismiss),
    .hour(hour), .min(min), .sec(sec), .disp_hour(disp_hour), .pm(pm),
    .sec_tick(sec_tick), .ringing(ringing), .snoozing(snoozing),
    .ring_slot(ring_slot), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_p = 0; m_st = 0; m_rc = 0; m_slot = 0; m_tgt = 0; m_err = 0;
    for (int i = 0; i < N_ALARMS; i++) begin
      m_sh[i] = 0; m_sm[i] = 0; m_se[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tick, tv, av, mev;
    int nhm, hit;
    tick = (m_p == CLK_HZ - 1);
    tv   = time_wr && wr_hour < 24 && wr_min < 60 && wr_sec < 60;
    av   = alarm_wr && alarm_idx < N_ALARMS && alarm_hour < 24 && alarm_min < 60;
    mev  = tick && !tv && (m_t % 60 == 59);
    nhm  = ((m_t + 1) % 86400) / 60;
    hit  = -1;
    for (int i = 0; i < N_ALARMS; i++)
      if (hit < 0 && m_se[i] != 0 && m_sh[i] * 60 + m_sm[i] == nhm) hit = i;
    case (m_st)
      0: if (mev && hit >= 0) begin m_st = 1; m_rc = 0; m_slot = hit; end
      1: begin
        if (dismiss) m_st = 0;
        else if (snooze) begin m_st = 2; m_tgt = (m_t / 60 + SNOOZE_MIN) % 1440; end
        else if (tick) begin
          if (m_rc == RING_SECS - 1) m_st = 0;
          else m_rc++;
        end
      end
      default: begin
        if (dismiss) m_st = 0;
        else if (mev && nhm == m_tgt) begin m_st = 1; m_rc = 0; end
        else if (mev && hit >= 0) begin m_st = 1; m_rc = 0; m_slot = hit; end
      end
    endcase
    if (av) begin
      m_sh[alarm_idx] = alarm_hour; m_sm[alarm_idx] = alarm_min; m_se[alarm_idx] = alarm_en;
    end
    m_err = ((time_wr && !tv) || (alarm_wr && !av)) ? 1 : 0;
    if (tv)        m_t = wr_hour * 3600 + wr_min * 60 + wr_sec;
    else if (tick) m_t = (m_t + 1) % 86400;
    m_p = tv ? 0 : (m_p + 1) % CLK_HZ;
  endtask

  // One clock: predict, clock, compare all outputs, then drop the one-cycle pulses.
  task automatic cyc();
    int h, dh;
    if (!reset) check("sec_tick", sec_tick, (m_p == CLK_HZ - 1) ? 1 : 0);
    if (reset) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
    h  = m_t / 3600;
    dh = !mode12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    check("hour", hour, h);
    check("min", min, (m_t / 60) % 60);
    check("sec", sec, m_t % 60);
    check("ringing", ringing, (m_st == 1) ? 1 : 0);
    check("snoozing", snoozing, (m_st == 2) ? 1 : 0);
    check("ring_slot", ring_slot, m_slot);
    check("wr_err", wr_err, m_err);
    check("disp_hour", disp_hour, dh);
    check("pm", pm, (h >= 12) ? 1 : 0);
    reset = 1'b0; time_wr = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    time_wr = 1'b1; wr_hour = 5'(h); wr_min = 6'(m); wr_sec = 6'(s);
    cyc();
  endtask

  task automatic set_alarm(input int idx, input int h, input int m, input bit en);
    alarm_wr = 1'b1; alarm_idx = 3'(idx); alarm_hour = 5'(h); alarm_min = 6'(m); alarm_en = en;
    cyc();
  endtask

  initial begin
    int ticks, wraps, was_nonzero;
    reset = 1'b1; mode12 = 1'b0; time_wr = 1'b0; alarm_wr = 1'b0; alarm_en = 1'b0;
    snooze = 1'b0; dismiss = 1'b0; wr_hour = '0; wr_min = '0; wr_sec = '0;
    alarm_idx = '0; alarm_hour = '0; alarm_min = '0;
    model_reset();
    cyc();
    check("reset_ring_slot", ring_slot, 0);
    check("reset_wr_err", wr_err, 0);

    // Midnight wrap: 15 seconds from 23:59:50 cross 00:00:00 exactly once.
    set_time(23, 59, 50);
    ticks = 0; wraps = 0;
    for (int i = 0; i < 15 * CLK_HZ; i++) begin
      ticks += sec_tick;
      was_nonzero = (hour != 0 || min != 0 || sec != 0) ? 1 : 0;
      cyc();
      if (was_nonzero != 0 && hour == 0 && min == 0 && sec == 0) wraps++;
    end
    check("tick_count", ticks, 15);
    check("wrap_count", wraps, 1);

    // Enabled slot 2 rings at midnight; disabled slot 1 at the same time does not.
    set_alarm(2, 0, 0, 1'b1);
    set_alarm(1, 0, 0, 1'b0);
    set_time(23, 59, 59);
    cycles(CLK_HZ);
    check("mid_ringing", ringing, 1);
    check("mid_ring_slot", ring_slot, 2);
    check("mid_sec", sec, 0);
    cycles(RING_SECS * CLK_HZ - 1);
    check("ring_before_timeout", ringing, 1);
    cyc();
    check("ring_after_timeout", ringing, 0);
    check("idle_after_timeout", snoozing, 0);

    // Snooze across midnight: 23:58 + 5 min -> 00:03.
    set_alarm(2, 0, 0, 1'b0);
    set_alarm(0, 23, 58, 1'b1);
    set_time(23, 57, 59);
    cycles(CLK_HZ);
    check("snz_ring", ringing, 1);
    snooze = 1'b1;
    cyc();
    check("snz_state", snoozing, 1);
    set_time(0, 2, 59);
    cycles(CLK_HZ);
    check("snz_rering", ringing, 1);
    check("snz_min", min, 3);
    check("snz_slot", ring_slot, 0);
    snooze = 1'b1; dismiss = 1'b1;
    cyc();
    check("dismiss_wins_ring", ringing, 0);
    check("dismiss_wins_snz", snoozing, 0);

    // Two slots at 07:30: lowest index wins; a later match while ringing is ignored.
    set_alarm(0, 7, 30, 1'b1);
    set_alarm(3, 7, 30, 1'b1);
    set_time(7, 29, 59);
    cycles(CLK_HZ);
    check("prio_slot", ring_slot, 0);
    set_alarm(1, 7, 31, 1'b1);
    set_time(7, 30, 58);
    cycles(2 * CLK_HZ);
    check("second_match_ringing", ringing, 1);
    check("second_match_slot", ring_slot, 0);
    dismiss = 1'b1;
    cyc();

    // Rejected writes.
    set_time(24, 0, 0);
    check("err_time", wr_err, 1);
    set_alarm(5, 1, 1, 1'b1);
    check("err_idx", wr_err, 1);
    set_alarm(0, 1, 60, 1'b1);
    check("err_min", wr_err, 1);

    // 12 h display.
    mode12 = 1'b1;
    set_time(0, 10, 0);
    check("disp_h0", disp_hour, 12);
    check("pm_h0", pm, 0);
    set_time(12, 0, 0);
    check("disp_h12", disp_hour, 12);
    check("pm_h12", pm, 1);
    set_time(13, 0, 0);
    check("disp_h13", disp_hour, 1);
    check("pm_h13", pm, 1);

    // Randomized traffic, biased so alarms land near the model's current time.
    for (int n = 0; n < 20000; n++) begin
      mode12 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1999) == 0) reset = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        time_wr = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          wr_hour = 5'($urandom_range(0, 25));
          wr_min  = 6'($urandom_range(0, 61));
          wr_sec  = 6'($urandom_range(0, 61));
        end else begin
          wr_hour = 5'($urandom_range(22, 23));
          wr_min  = 6'($urandom_range(55, 59));
          wr_sec  = 6'($urandom_range(40, 59));
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        int hm;
        alarm_wr  = 1'b1;
        alarm_idx = 3'($urandom_range(0, 5));
        alarm_en  = 1'($urandom_range(0, 3) != 0);
        hm = (m_t / 60 + $urandom_range(0, 2)) % 1440;
        alarm_hour = 5'(hm / 60);
        alarm_min  = 6'(hm % 60);
        if ($urandom_range(0, 7) == 0) alarm_min = 6'($urandom_range(58, 63));
      end
      if ($urandom_range(0, 39) == 0) snooze = 1'b1;
      if ($urandom_range(0, 59) == 0) dismiss = 1'b1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
